word_serializer: RTL

- Parallel-to-serial stage directly upstream of the 1101 sequence detector.
- Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clock on x, with x_valid as a qualifier.
- Back-to-back words stream with no idle gap, so bit patterns that straddle a word boundary stay contiguous for the detector.

---
 rtl/word_serializer_if.sv | 50 +++++
 rtl/word_serializer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/word_serializer_if.sv
// rtl/word_serializer_if.sv - handshake and serial-output bundle for word_serializer
//
// Purpose: carries the parallel word handshake into the serializer and the
// registered serial stream plus status back out.
//
// Signals:
//   in_data   WIDTH  parallel word, sampled only on accept
//   in_valid  1      upstream word available
//   in_ready  1      serializer can accept a word this cycle
//   x         1      serial bit to the detector
//   x_valid   1      x carries a data bit this cycle
//   busy      1      serializer is shifting a word
//   bit_idx   IDX_W  index of the bit currently on x, 0 = first transmitted
//
// Modports:
//   master  upstream producer / observer side
//   slave   serializer side
interface word_serializer_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic [IDX_W-1:0] bit_idx;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  x,
        input  x_valid,
        input  busy,
        input  bit_idx
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output x,
        output x_valid,
        output busy,
        output bit_idx
    );
endinterface

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - parallel-to-serial stage feeding the 1101 sequence detector
//
// Purpose: accepts WIDTH-bit words on a valid/ready handshake and emits them
// one bit per clock on x, qualified by x_valid. A word offered on the last-bit
// cycle is loaded at that edge, so consecutive words stream with no idle gap
// and patterns that straddle a word boundary stay contiguous downstream.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1 = in_data[WIDTH-1] goes out first, 0 = in_data[0] first
//   IDLE_BIT   value held on x while no word is being shifted
//
// Ports:
//   clk  input  rising-edge system clock
//   clr  input  asynchronous active-low reset
//   bus  slave  handshake and serial output bundle (word_serializer_if)
module word_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic               clk,
    input  logic               clr,
    word_serializer_if.slave   bus
);

    localparam int               IDX_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    // Holds the bits not yet placed on x; the bit on x lives in x_q.
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;

    logic             on_last;
    logic             ready;
    logic             accept;

    // Ready in IDLE, and on the last bit of a word so the next word follows
    // without a gap.
    assign on_last = (state_q == S_SHIFT) && (bit_idx_q == LAST);
    assign ready   = (state_q == S_IDLE) || on_last;
    assign accept  = bus.in_valid && ready;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        x_d       = x_q;
        x_valid_d = x_valid_q;
        busy_d    = busy_q;

        if (accept) begin
            // The first bit goes straight to x; the rest is pre-shifted so
            // the next edge can take the next bit from the register's end.
            state_d   = S_SHIFT;
            bit_idx_d = '0;
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
            if (MSB_FIRST) begin
                x_d     = bus.in_data[WIDTH-1];
                shreg_d = {bus.in_data[WIDTH-2:0], 1'b0};
            end else begin
                x_d     = bus.in_data[0];
                shreg_d = {1'b0, bus.in_data[WIDTH-1:1]};
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    x_d       = IDLE_BIT;
                    x_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    bit_idx_d = '0;
                end
                S_SHIFT: begin
                    if (on_last) begin
                        // Word complete and nothing offered: drop back to idle.
                        state_d   = S_IDLE;
                        shreg_d   = '0;
                        bit_idx_d = '0;
                        x_d       = IDLE_BIT;
                        x_valid_d = 1'b0;
                        busy_d    = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (MSB_FIRST) begin
                            x_d     = shreg_q[WIDTH-1];
                            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        end else begin
                            x_d     = shreg_q[0];
                            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                        end
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    shreg_d   = '0;
                    bit_idx_d = '0;
                    x_d       = IDLE_BIT;
                    x_valid_d = 1'b0;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    // Reset discards any word in flight; nothing is completed afterwards.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.in_ready = ready;
    assign bus.x        = x_q;
    assign bus.x_valid  = x_valid_q;
    assign bus.busy     = busy_q;
    assign bus.bit_idx  = bit_idx_q;

endmodule
